// File: rtl/wb_select_stage.sv
// MIPS writeback stage: registers MEM/WB, selects among up to four result sources,
// formats sub-word loads and inserts bubbles while data memory is not ready.
module wb_select_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NSRC   = 3,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_regwrite,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [1:0]        in_sel,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_mem,
   input  logic              in_mem_ready,
   input  logic [2:0]        in_load_type,
   input  logic [1:0]        in_addr_lo,
   input  logic [DATA_W-1:0] in_link,
   input  logic [DATA_W-1:0] in_aux,
   input  logic              stall,
   input  logic              flush,
   output logic              stall_req,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [REG_AW-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data
);

   logic [31:0]       mem_lo;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DATA_W-1:0] ld_data;
   logic [DATA_W-1:0] sel_data;
   logic              mem_wait;

   logic              wb_valid_d, wb_valid_q;
   logic              wb_we_d, wb_we_q;
   logic [REG_AW-1:0] wb_rd_d, wb_rd_q;
   logic [DATA_W-1:0] wb_data_d, wb_data_q;

   // Byte lanes always come from the low 32-bit word; narrow datapaths see zero lanes.
   if (DATA_W >= 32) begin : g_wide
      assign mem_lo = in_mem[31:0];
   end else begin : g_narrow
      assign mem_lo = {{(32 - DATA_W){1'b0}}, in_mem};
   end

   always_comb begin
      ld_byte = mem_lo[7:0];
      unique case (in_addr_lo)
         2'd0: ld_byte = mem_lo[7:0];
         2'd1: ld_byte = mem_lo[15:8];
         2'd2: ld_byte = mem_lo[23:16];
         2'd3: ld_byte = mem_lo[31:24];
         default: ld_byte = mem_lo[7:0];
      endcase
      ld_half = in_addr_lo[1] ? mem_lo[31:16] : mem_lo[15:0];
   end

   always_comb begin
      case (in_load_type)
         3'b001:  ld_data = {{(DATA_W - 8){ld_byte[7]}}, ld_byte};
         3'b010:  ld_data = {{(DATA_W - 8){1'b0}}, ld_byte};
         3'b011:  ld_data = {{(DATA_W - 16){ld_half[15]}}, ld_half};
         3'b100:  ld_data = {{(DATA_W - 16){1'b0}}, ld_half};
         default: ld_data = in_mem;
      endcase
   end

   // Selects beyond NSRC yield zero data but still write, matching the old mux.
   always_comb begin
      sel_data = '0;
      if (32'(in_sel) < NSRC) begin
         unique case (in_sel)
            2'd0: sel_data = in_alu;
            2'd1: sel_data = ld_data;
            2'd2: sel_data = in_link;
            2'd3: sel_data = in_aux;
            default: sel_data = '0;
         endcase
      end
   end

   assign mem_wait  = in_valid & (in_sel == 2'd1) & ~in_mem_ready & ~flush;
   assign stall_req = mem_wait | stall;

   always_comb begin
      wb_valid_d = wb_valid_q;
      wb_we_d    = wb_we_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      if (flush || (!stall && mem_wait)) begin
         wb_valid_d = 1'b0;
         wb_we_d    = 1'b0;
         wb_rd_d    = '0;
         wb_data_d  = '0;
      end else if (!stall) begin
         wb_valid_d = in_valid;
         wb_we_d    = in_valid & in_regwrite & (in_rd != '0);
         wb_rd_d    = in_rd;
         wb_data_d  = sel_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
      end else begin
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_we    = wb_we_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: directed scenarios plus randomized traffic
// compared against a behavioural writeback model.
module tb_wb_select_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_regwrite, in_mem_ready, stall, flush;
   logic [4:0]  in_rd;
   logic [1:0]  in_sel, in_addr_lo;
   logic [2:0]  in_load_type;
   logic [31:0] in_alu, in_mem, in_link, in_aux;
   logic        stall_req, wb_valid, wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_select_stage #(.DATA_W(32), .NSRC(3), .REG_AW(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_regwrite  (in_regwrite),
      .in_rd        (in_rd),
      .in_sel       (in_sel),
      .in_alu       (in_alu),
      .in_mem       (in_mem),
      .in_mem_ready (in_mem_ready),
      .in_load_type (in_load_type),
      .in_addr_lo   (in_addr_lo),
      .in_link      (in_link),
      .in_aux       (in_aux),
      .stall        (stall),
      .flush        (flush),
      .stall_req    (stall_req),
      .wb_valid     (wb_valid),
      .wb_we        (wb_we),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data)
   );

   // Reference result: extract the addressed field arithmetically, then extend.
   function automatic logic [31:0] ref_data(input logic [1:0] sel, input logic [2:0] lt,
                                            input logic [1:0] a, input logic [31:0] alu,
                                            input logic [31:0] mem, input logic [31:0] link);
      logic [31:0] v;
      case (sel)
         2'd0: v = alu;
         2'd2: v = link;
         2'd1: begin
            if (lt == 3'd1 || lt == 3'd2) begin
               v = (mem >> (8 * a)) & 32'h0000_00FF;
               if (lt == 3'd1 && v[7]) v = v | 32'hFFFF_FF00;
            end else if (lt == 3'd3 || lt == 3'd4) begin
               v = (mem >> (16 * a[1])) & 32'h0000_FFFF;
               if (lt == 3'd3 && v[15]) v = v | 32'hFFFF_0000;
            end else begin
               v = mem;
            end
         end
         default: v = 32'h0;  // NSRC=3: AUX is an illegal select
      endcase
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_regwrite = 0; in_rd = 0; in_sel = 0; in_alu = 0; in_mem = 0;
      in_mem_ready = 1; in_load_type = 0; in_addr_lo = 0; in_link = 0; in_aux = 0;
      stall = 0; flush = 0;
   endtask

   task automatic test_reset();
      in_valid = 1; in_regwrite = 1; in_rd = 5'($urandom); in_sel = 2'($urandom);
      in_alu = $urandom; in_mem = $urandom; in_mem_ready = 1; in_load_type = 0;
      in_addr_lo = 0; in_link = $urandom; in_aux = $urandom; stall = 0; flush = 0;
      rst = 1;
      step();
      step();
      n_checks += 4;
      if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", wb_valid); end
      if (wb_we !== 1'b0)    begin n_fail++; $display("FAIL reset_we got %b exp 0", wb_we); end
      if (wb_rd !== 5'd0)    begin n_fail++; $display("FAIL reset_rd got %0d exp 0", wb_rd); end
      if (wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", wb_data); end
      rst = 0;
      idle_inputs();
      #1;
      n_checks++;
      if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall_req got %b exp 0", stall_req); end
      step();
   endtask

   task automatic test_source_sweep();
      logic [1:0]  sels [4] = '{2'd0, 2'd2, 2'd3, 2'd0};
      logic [4:0]  rds  [4] = '{5'd5, 5'd5, 5'd5, 5'd0};
      logic [31:0] exp_d[4] = '{32'h1111_1111, 32'h0040_0008, 32'h0, 32'h1111_1111};
      logic        exp_w[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      idle_inputs();
      in_alu = 32'h1111_1111; in_link = 32'h0040_0008; in_aux = 32'hDEAD_BEEF;
      in_valid = 1; in_regwrite = 1;
      for (int i = 0; i < 4; i++) begin
         in_sel = sels[i]; in_rd = rds[i];
         step();
         n_checks += 3;
         if (wb_data !== exp_d[i]) begin
            n_fail++; $display("FAIL src_data[%0d] got %h exp %h", i, wb_data, exp_d[i]);
         end
         if (wb_we !== exp_w[i]) begin
            n_fail++; $display("FAIL src_we[%0d] got %b exp %b", i, wb_we, exp_w[i]);
         end
         if (wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL src_valid[%0d] got %b exp 1", i, wb_valid);
         end
      end
   endtask

   task automatic test_load_format();
      logic [2:0]  lts  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      logic [1:0]  as   [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
      logic [31:0] exp_d[5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01,
                                32'h80FF_7F01};
      idle_inputs();
      in_valid = 1; in_regwrite = 1; in_rd = 5'd9; in_sel = 2'd1; in_mem = 32'h80FF_7F01;
      for (int i = 0; i < 5; i++) begin
         in_load_type = lts[i]; in_addr_lo = as[i];
         step();
         n_checks++;
         if (wb_data !== exp_d[i]) begin
            n_fail++; $display("FAIL load_fmt[%0d] got %h exp %h", i, wb_data, exp_d[i]);
         end
      end
   endtask

   task automatic test_mem_wait();
      int req_cycles = 0;
      idle_inputs();
      in_valid = 1; in_regwrite = 1; in_rd = 5'd12; in_sel = 2'd1; in_load_type = 3'd0;
      in_mem = 32'hCAFE_F00D; in_mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (stall_req === 1'b1) req_cycles++;
         step();
         n_checks++;
         if (wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL wait_bubble[%0d] got %b exp 0", i, wb_valid);
         end
      end
      in_mem_ready = 1;
      #1;
      if (stall_req === 1'b1) req_cycles++;
      n_checks++;
      if (req_cycles != 3) begin
         n_fail++; $display("FAIL wait_stall_req_cycles got %0d exp 3", req_cycles);
      end
      step();
      n_checks += 2;
      if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL wait_capture_valid got %b exp 1", wb_valid); end
      if (wb_data !== 32'hCAFE_F00D) begin
         n_fail++; $display("FAIL wait_capture_data got %h exp cafef00d", wb_data);
      end
   endtask

   task automatic test_stall_flush();
      idle_inputs();
      in_valid = 1; in_regwrite = 1; in_rd = 5'd7; in_sel = 2'd0; in_alu = 32'hA5A5_5A5A;
      step();
      // Inputs change while stalled; the stage must ignore them.
      stall = 1; in_alu = 32'h0BAD_0BAD; in_rd = 5'd3;
      #1;
      n_checks++;
      if (stall_req !== 1'b1) begin n_fail++; $display("FAIL stall_req got %b exp 1", stall_req); end
      step();
      step();
      n_checks += 4;
      if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_valid got %b exp 1", wb_valid); end
      if (wb_we !== 1'b1)    begin n_fail++; $display("FAIL stall_hold_we got %b exp 1", wb_we); end
      if (wb_rd !== 5'd7)    begin n_fail++; $display("FAIL stall_hold_rd got %0d exp 7", wb_rd); end
      if (wb_data !== 32'hA5A5_5A5A) begin
         n_fail++; $display("FAIL stall_hold_data got %h exp a5a55a5a", wb_data);
      end
      flush = 1;
      step();
      n_checks += 2;
      if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin
         n_fail++; $display("FAIL flush_stall_bubble got v=%b we=%b exp 0 0", wb_valid, wb_we);
      end
      if (wb_rd !== 5'd0 || wb_data !== 32'h0) begin
         n_fail++; $display("FAIL flush_stall_zero got rd=%0d d=%h exp 0 0", wb_rd, wb_data);
      end
      stall = 0; flush = 0; in_sel = 2'd0; in_rd = 5'd4;
      step();
      in_sel = 2'd1; in_mem_ready = 0; flush = 1;
      #1;
      n_checks++;
      if (stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_wait_req got %b exp 0", stall_req); end
      step();
      n_checks++;
      if (wb_valid !== 1'b0 || wb_data !== 32'h0) begin
         n_fail++; $display("FAIL flush_wait_bubble got v=%b d=%h exp 0 0", wb_valid, wb_data);
      end
      flush = 0; in_mem_ready = 1;
   endtask

   task automatic randomize_instr(input logic all_valid);
      in_valid     = all_valid ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      in_regwrite  = 1'($urandom);
      in_rd        = 5'($urandom);
      in_sel       = 2'($urandom);
      in_alu       = $urandom;
      in_mem       = $urandom;
      in_load_type = 3'($urandom);
      in_addr_lo   = 2'($urandom);
      in_link      = $urandom;
      in_aux       = $urandom;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_q[$];
      logic        exp_we_q[$];
      logic [4:0]  exp_rd_q[$];
      idle_inputs();
      for (int i = 0; i < 8; i++) begin
         randomize_instr(1'b1);
         exp_q.push_back(ref_data(in_sel, in_load_type, in_addr_lo, in_alu, in_mem, in_link));
         exp_we_q.push_back(in_regwrite && in_rd != 0);
         exp_rd_q.push_back(in_rd);
         step();
         n_checks += 2;
         if (wb_valid !== 1'b1 || wb_data !== exp_q[0] || wb_rd !== exp_rd_q[0]) begin
            n_fail++;
            $display("FAIL b2b[%0d] got v=%b rd=%0d d=%h exp v=1 rd=%0d d=%h", i, wb_valid,
                     wb_rd, wb_data, exp_rd_q[0], exp_q[0]);
         end
         if (wb_we !== exp_we_q[0]) begin
            n_fail++; $display("FAIL b2b_we[%0d] got %b exp %b", i, wb_we, exp_we_q[0]);
         end
         void'(exp_q.pop_front());
         void'(exp_we_q.pop_front());
         void'(exp_rd_q.pop_front());
      end
   endtask

   task automatic test_random();
      logic        m_valid = wb_valid, m_we = wb_we;
      logic [4:0]  m_rd = wb_rd;
      logic [31:0] m_data = wb_data;
      logic        prev_req = 1'b0;
      logic        waiting, exp_req;
      // Start from a known, modelled state.
      idle_inputs();
      step();
      m_valid = 0; m_we = 0;
      for (int c = 0; c < 300; c++) begin
         if (!prev_req) randomize_instr(1'b0);
         in_mem_ready = 1'($urandom_range(0, 9) < 6);
         stall        = 1'($urandom_range(0, 9) < 2);
         flush        = 1'($urandom_range(0, 19) == 0);
         waiting = in_valid && in_sel == 2'd1 && !in_mem_ready && !flush;
         exp_req = waiting || stall;
         #1;
         n_checks++;
         if (stall_req !== exp_req) begin
            n_fail++; $display("FAIL rnd_stall_req[%0d] got %b exp %b", c, stall_req, exp_req);
         end
         if (flush || (!stall && waiting)) begin
            m_valid = 0; m_we = 0; m_rd = 0; m_data = 0;
         end else if (!stall) begin
            m_valid = in_valid;
            m_we    = in_valid && in_regwrite && in_rd != 0;
            m_rd    = in_rd;
            m_data  = ref_data(in_sel, in_load_type, in_addr_lo, in_alu, in_mem, in_link);
         end
         prev_req = exp_req;
         step();
         n_checks++;
         if (wb_valid !== m_valid || wb_we !== m_we ||
             (m_valid && (wb_rd !== m_rd || wb_data !== m_data))) begin
            n_fail++;
            $display("FAIL rnd_out[%0d] got v=%b we=%b rd=%0d d=%h exp v=%b we=%b rd=%0d d=%h",
                     c, wb_valid, wb_we, wb_rd, wb_data, m_valid, m_we, m_rd, m_data);
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_source_sweep();
      test_load_format();
      test_mem_wait();
      test_stall_flush();
      test_back_to_back();
      test_random();
      rst = 1;
      test_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_select_stage.md
# wb_select_stage

Parametrised writeback stage for the 5-stage MIPS pipeline, successor to the combinational 3:1 writeback multiplexer. It registers the MEM/WB boundary, selects among up to four result sources, sign- or zero-extends sub-word loads, and inserts bubbles while the data memory is not ready. Its outputs drive the register-file write port and the WB-stage forwarding path.

## Interface
Parameters:
- DATA_W, 32, datapath width; multiple of 8, at least 16.
- NSRC, 3, number of legal sources, 2..4.
  - Codes: 0 = ALU, 1 = MEM, 2 = LINK, 3 = AUX.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present at the MEM/WB input.
- in_regwrite  in  1  instruction writes a register.
- in_rd  in  REG_AW  destination register.
- in_sel  in  2  source select.
- in_alu  in  DATA_W  ALU result.
- in_mem  in  DATA_W  raw memory read word.
- in_mem_ready  in  1  in_mem is valid this cycle.
- in_load_type  in  3  load format.
  - 000: word.
  - 001: byte, signed.
  - 010: byte, unsigned.
  - 011: half, signed.
  - 100: half, unsigned.
  - Other codes: word.
- in_addr_lo  in  2  low bits of the load address.
- in_link  in  DATA_W  link address for jal/jalr.
- in_aux  in  DATA_W  auxiliary result, e.g. HI/LO move.
- stall  in  1  hold the stage (downstream/hazard stall).
- flush  in  1  kill the instruction being captured.
- stall_req  out  1  combinational; upstream must hold MEM/WB inputs.
- wb_valid  out  1  registered; valid instruction in WB.
- wb_we  out  1  registered; register-file write enable.
- wb_rd  out  REG_AW  registered; write address.
- wb_data  out  DATA_W  registered; write data.

## Operation
- Source select (combinational, before the register):
  - ALU → in_alu.
  - MEM → in_mem after load formatting.
  - LINK → in_link.
  - AUX → in_aux.
  - in_sel ≥ NSRC → all-zero data. The write still occurs if enabled, preserving the legacy behaviour for an undefined select.
- Load formatting, little-endian byte lanes:
  - Byte: lane in_addr_lo selects bits [8*a+7 : 8*a].
  - Half: in_addr_lo[1] selects the lower or upper half; in_addr_lo[0] is ignored.
  - Signed formats replicate the MSB of the extracted field to DATA_W.
  - Unsigned formats zero-fill.
  - Word passes unchanged.
- Memory wait: mem_wait = in_valid & (in_sel==1) & ~in_mem_ready & ~flush.
  - stall_req = mem_wait | stall.
- Write enable: wb_we = wb_valid & in_regwrite & (in_rd != 0). Register $0 is never written.
- Priority on each clock edge, highest first:
  1. rst: all outputs become 0.
  2. flush: load a bubble (wb_valid=0, wb_we=0, wb_rd=0, wb_data=0).
  3. stall: hold all registers.
  4. mem_wait: load a bubble.
  5. Otherwise: capture wb_valid=in_valid, plus the formatted data, rd and write enable.
- A bubble always has wb_valid=0, wb_we=0, wb_rd=0, wb_data=0.
- Upstream contract: while stall_req=1, all in_* inputs are held stable.

## Timing
- Latency: one cycle from capture to wb_* outputs. Throughput is one instruction per cycle when there are no stalls.
- Reset values: wb_valid=0, wb_we=0, wb_rd=0, wb_data=0. stall_req follows its inputs and is 0 when in_valid=0 and stall=0.
- Reset mid-wait: a pending MEM instruction is discarded. Upstream replays or flushes it according to its own reset.
- Memory wait: each cycle with in_mem_ready=0 emits one bubble. In the cycle in_mem_ready rises, stall_req=0 and the formatted data is captured on that edge.
- Simultaneous flush and stall: flush wins and a bubble is loaded.
- Simultaneous flush and mem_wait: flush wins and stall_req deasserts, unless stall is high.
- stall with no valid input: registers hold; wb_we stays at its held value. The register file is edge-written, so a write enable held across a stall must be gated by the hazard unit; this block does not re-qualify it.

## Test plan
- Reset: assert rst for 2 cycles with arbitrary inputs → wb_valid=0, wb_we=0, wb_rd=0, wb_data=0. stall_req=0 with in_valid=0 and stall=0.
- Source sweep (NSRC=3): in_alu=0x11111111, in_link=0x00400008, rd=5, regwrite=1.
  - sel=0 → wb_data=0x11111111 next cycle, wb_we=1.
  - sel=2 → 0x00400008.
  - sel=3 → 0x00000000.
  - rd=0 → wb_we=0.
- Load formatting with in_mem=0x80FF7F01:
  - lb, a=3 → 0xFFFFFF80.
  - lbu, a=1 → 0x0000007F.
  - lh, a=2 → 0xFFFF80FF.
  - lhu, a=0 → 0x00007F01.
  - lw → 0x80FF7F01.
- Memory wait: sel=1 with in_mem_ready low for 3 cycles, then high.
  - stall_req=1 for exactly 3 cycles.
  - 3 bubbles on wb_valid.
  - Data captured on the 4th edge, so wb_valid=1 on the following cycle.
- Stall/flush priority:
  - stall=1 for 2 cycles → wb_* frozen.
  - flush=1 together with stall=1 → bubble next cycle.
  - flush during a mem_wait → stall_req=0 and a bubble.
- Back-to-back stream: 8 consecutive valid instructions with mixed sel → outputs in order, one per cycle, each with 1-cycle latency. Check against a reference model.
